// File: rtl/alu_op_sequencer.sv
// Multi-cycle instruction sequencer driving register file, A/B/C/status loads and ALU selects.
// Optional build macro STATUS_ALL_OPS_EN: status register also loads on ADD, AND and MVN results.
module alu_op_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             instr_valid,
  input  logic [15:0]      instr,
  output logic             instr_ready,
  output logic             done,
  output logic             err,
  output logic [2:0]       readnum,
  output logic [2:0]       writenum,
  output logic             write,
  output logic             vsel,
  output logic             loada,
  output logic             loadb,
  output logic             loadc,
  output logic             loads,
  output logic             asel,
  output logic [1:0]       shift,
  output logic [WIDTH-1:0] sximm,
  output logic             add_sub_vals,
  output logic             and_vals,
  output logic             not_b_val,
  output logic             sub
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_WRITE,
    S_ERR
  } state_t;

`ifdef STATUS_ALL_OPS_EN
  localparam bit StatusAllOps = 1'b1;
`else
  localparam bit StatusAllOps = 1'b0;
`endif

  state_t      state_q, state_d;
  logic [15:0] instr_q, instr_d;

  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn, rd, rm;
  logic [1:0] shift_f;
  logic [7:0] imm8;

  assign opcode  = instr_q[15:13];
  assign op      = instr_q[12:11];
  assign rn      = instr_q[10:8];
  assign rd      = instr_q[7:5];
  assign shift_f = instr_q[4:3];
  assign rm      = instr_q[2:0];
  assign imm8    = instr_q[7:0];

  logic is_mov_imm, is_mov_reg, is_add, is_cmp, is_and, is_mvn;

  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_add     = (opcode == 3'b101) && (op == 2'b00);
  assign is_cmp     = (opcode == 3'b101) && (op == 2'b01);
  assign is_and     = (opcode == 3'b101) && (op == 2'b10);
  assign is_mvn     = (opcode == 3'b101) && (op == 2'b11);

  // sximm follows the latched word, so it stays stable until the next accept
  assign sximm = {{(WIDTH-8){imm8[7]}}, imm8};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    instr_d = instr_q;
    if (state_q == S_IDLE && instr_valid) begin
      instr_d = instr;
    end
  end

  always_comb begin
    state_d      = state_q;
    instr_ready  = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    readnum      = 3'd0;
    writenum     = 3'd0;
    write        = 1'b0;
    vsel         = 1'b0;
    loada        = 1'b0;
    loadb        = 1'b0;
    loadc        = 1'b0;
    loads        = 1'b0;
    asel         = 1'b0;
    shift        = 2'b00;
    add_sub_vals = 1'b0;
    and_vals     = 1'b0;
    not_b_val    = 1'b0;
    sub          = 1'b0;

    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        if (is_mov_imm) begin
          state_d = S_WRITE;
        end else if (is_mov_reg || is_mvn) begin
          state_d = S_GET_B;
        end else if (is_add || is_cmp || is_and) begin
          state_d = S_GET_A;
        end else begin
          state_d = S_ERR;
        end
      end

      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
        state_d = S_GET_B;
      end

      S_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
        shift   = shift_f;
        state_d = S_EXEC;
      end

      // MOV Rd,Rm passes B through the adder with A forced to zero
      S_EXEC: begin
        shift        = shift_f;
        add_sub_vals = is_mov_reg || is_add || is_cmp;
        and_vals     = is_and;
        not_b_val    = is_mvn;
        sub          = is_cmp;
        asel         = is_mov_reg;
        if (is_cmp) begin
          loads   = 1'b1;
          done    = 1'b1;
          state_d = S_IDLE;
        end else begin
          loadc   = 1'b1;
          loads   = StatusAllOps && (is_add || is_and || is_mvn);
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        write = 1'b1;
        done  = 1'b1;
        if (is_mov_imm) begin
          writenum = rn;
          vsel     = 1'b1;
        end else begin
          writenum = rd;
        end
        state_d = S_IDLE;
      end

      S_ERR: begin
        done    = 1'b1;
        err     = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed table-driven bench for alu_op_sequencer plus hand-written reset-abort and busy-queue sequences.
// Build with STATUS_ALL_OPS_EN defined to check the all-ops status variant.
module tb_alu_op_sequencer;

  localparam int WIDTH = 16;

`ifdef STATUS_ALL_OPS_EN
  localparam logic STATUS_ALL = 1'b1;
`else
  localparam logic STATUS_ALL = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             instr_valid = 1'b0;
  logic [15:0]      instr = 16'h0000;
  logic             instr_ready, done, err;
  logic [2:0]       readnum, writenum;
  logic             write, vsel, loada, loadb, loadc, loads, asel;
  logic [1:0]       shift;
  logic [WIDTH-1:0] sximm;
  logic             add_sub_vals, and_vals, not_b_val, sub;

  alu_op_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .done(done), .err(err),
    .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads), .asel(asel),
    .shift(shift), .sximm(sximm), .add_sub_vals(add_sub_vals),
    .and_vals(and_vals), .not_b_val(not_b_val), .sub(sub)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ready;
    logic       done;
    logic       err;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       write;
    logic       vsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic [1:0] shift;
    logic       addsub;
    logic       andv;
    logic       notb;
    logic       sub;
  } ctrl_t;

  typedef struct {
    logic [15:0] instr;
    int          step;
    ctrl_t       exp;
    logic [15:0] sx;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic ctrl_t zero_c();
    ctrl_t c;
    c = '0;
    return c;
  endfunction

  function automatic ctrl_t idle_c();
    ctrl_t c;
    c = '0;
    c.ready = 1'b1;
    return c;
  endfunction

  function automatic void add(input logic [15:0] i, input int s, input ctrl_t c,
                              input logic [15:0] sx, input string n);
    vec_t v;
    v.instr = i; v.step = s; v.exp = c; v.sx = sx; v.name = n;
    vecs.push_back(v);
  endfunction

  function automatic ctrl_t actual_c();
    ctrl_t a;
    a.ready = instr_ready; a.done = done; a.err = err;
    a.readnum = readnum; a.writenum = writenum; a.write = write; a.vsel = vsel;
    a.loada = loada; a.loadb = loadb; a.loadc = loadc; a.loads = loads; a.asel = asel;
    a.shift = shift; a.addsub = add_sub_vals; a.andv = and_vals; a.notb = not_b_val;
    a.sub = sub;
    return a;
  endfunction

  task automatic checkOutput(input string name, input ctrl_t exp, input logic [15:0] exp_sx);
    ctrl_t a;
    a = actual_c();
    vectors++;
    if (a !== exp || sximm !== exp_sx) begin
      miscompares++;
      $display("[TB] FAIL %s: got ctrl=%06h sximm=%04h, expected ctrl=%06h sximm=%04h",
               name, a, sximm, exp, exp_sx);
    end
  endtask

  // Called at a negedge; returns at the negedge of the first cycle after acceptance.
  task automatic applyStimulus(input logic [15:0] i);
    int budget;
    budget = 20;
    while (!instr_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!instr_ready) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL accept_timeout: instr_ready=%0b, required 1", instr_ready);
    end
    instr = i;
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    ctrl_t c;

    // MOV R1,#-1
    add(16'hD1FF, 1, zero_c(), 16'hFFFF, "movi_decode");
    c = zero_c(); c.write = 1; c.writenum = 3'd1; c.vsel = 1; c.done = 1;
    add(16'hD1FF, 2, c, 16'hFFFF, "movi_write");
    add(16'hD1FF, 3, idle_c(), 16'hFFFF, "movi_idle");

    // ADD R5,R0,R2 shift=01
    add(16'hA0AA, 1, zero_c(), 16'hFFAA, "add_decode");
    c = zero_c(); c.readnum = 3'd0; c.loada = 1;
    add(16'hA0AA, 2, c, 16'hFFAA, "add_get_a");
    c = zero_c(); c.readnum = 3'd2; c.loadb = 1; c.shift = 2'b01;
    add(16'hA0AA, 3, c, 16'hFFAA, "add_get_b");
    c = zero_c(); c.shift = 2'b01; c.addsub = 1; c.loadc = 1; c.loads = STATUS_ALL;
    add(16'hA0AA, 4, c, 16'hFFAA, "add_exec");
    c = zero_c(); c.write = 1; c.writenum = 3'd5; c.done = 1;
    add(16'hA0AA, 5, c, 16'hFFAA, "add_write");
    add(16'hA0AA, 6, idle_c(), 16'hFFAA, "add_idle");

    // CMP R1,R2
    add(16'hA902, 1, zero_c(), 16'h0002, "cmp_decode");
    c = zero_c(); c.readnum = 3'd1; c.loada = 1;
    add(16'hA902, 2, c, 16'h0002, "cmp_get_a");
    c = zero_c(); c.readnum = 3'd2; c.loadb = 1;
    add(16'hA902, 3, c, 16'h0002, "cmp_get_b");
    c = zero_c(); c.addsub = 1; c.sub = 1; c.loads = 1; c.done = 1;
    add(16'hA902, 4, c, 16'h0002, "cmp_exec");
    add(16'hA902, 5, idle_c(), 16'h0002, "cmp_idle");

    // MVN R3,R0
    add(16'hB860, 1, zero_c(), 16'h0060, "mvn_decode");
    c = zero_c(); c.readnum = 3'd0; c.loadb = 1;
    add(16'hB860, 2, c, 16'h0060, "mvn_get_b");
    c = zero_c(); c.notb = 1; c.loadc = 1; c.loads = STATUS_ALL;
    add(16'hB860, 3, c, 16'h0060, "mvn_exec");
    c = zero_c(); c.write = 1; c.writenum = 3'd3; c.done = 1;
    add(16'hB860, 4, c, 16'h0060, "mvn_write");
    add(16'hB860, 5, idle_c(), 16'h0060, "mvn_idle");

    // MOV R7,R3 shift=10
    add(16'hC0F3, 1, zero_c(), 16'hFFF3, "movr_decode");
    c = zero_c(); c.readnum = 3'd3; c.loadb = 1; c.shift = 2'b10;
    add(16'hC0F3, 2, c, 16'hFFF3, "movr_get_b");
    c = zero_c(); c.shift = 2'b10; c.asel = 1; c.addsub = 1; c.loadc = 1;
    add(16'hC0F3, 3, c, 16'hFFF3, "movr_exec");
    c = zero_c(); c.write = 1; c.writenum = 3'd7; c.done = 1;
    add(16'hC0F3, 4, c, 16'hFFF3, "movr_write");
    add(16'hC0F3, 5, idle_c(), 16'hFFF3, "movr_idle");

    // AND R4,R2,R1 shift=11
    add(16'hB299, 1, zero_c(), 16'hFF99, "and_decode");
    c = zero_c(); c.readnum = 3'd2; c.loada = 1;
    add(16'hB299, 2, c, 16'hFF99, "and_get_a");
    c = zero_c(); c.readnum = 3'd1; c.loadb = 1; c.shift = 2'b11;
    add(16'hB299, 3, c, 16'hFF99, "and_get_b");
    c = zero_c(); c.shift = 2'b11; c.andv = 1; c.loadc = 1; c.loads = STATUS_ALL;
    add(16'hB299, 4, c, 16'hFF99, "and_exec");
    c = zero_c(); c.write = 1; c.writenum = 3'd4; c.done = 1;
    add(16'hB299, 5, c, 16'hFF99, "and_write");
    add(16'hB299, 6, idle_c(), 16'hFF99, "and_idle");

    // Illegal encodings: opcode 111, and opcode 110 with op 01 / 11
    c = zero_c(); c.done = 1; c.err = 1;
    add(16'hE000, 1, zero_c(), 16'h0000, "err111_decode");
    add(16'hE000, 2, c, 16'h0000, "err111_err");
    add(16'hE000, 3, idle_c(), 16'h0000, "err111_idle");
    add(16'hC8F0, 1, zero_c(), 16'hFFF0, "err_c01_decode");
    add(16'hC8F0, 2, c, 16'hFFF0, "err_c01_err");
    add(16'hC8F0, 3, idle_c(), 16'hFFF0, "err_c01_idle");
    add(16'hD805, 1, zero_c(), 16'h0005, "err_c11_decode");
    add(16'hD805, 2, c, 16'h0005, "err_c11_err");
    add(16'hD805, 3, idle_c(), 16'h0005, "err_c11_idle");

    #2;
    checkOutput("reset_state", idle_c(), 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_idle", idle_c(), 16'h0000);

    foreach (vecs[k]) begin
      if (vecs[k].step == 1) applyStimulus(vecs[k].instr);
      else @(negedge clk);
      checkOutput(vecs[k].name, vecs[k].exp, vecs[k].sx);
    end

    // Reset asserted in the middle of an ADD's EXEC cycle
    applyStimulus(16'hA0AA);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    c = zero_c(); c.shift = 2'b01; c.addsub = 1; c.loadc = 1; c.loads = STATUS_ALL;
    checkOutput("rst_pre_exec", c, 16'hFFAA);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("rst_async_drop", idle_c(), 16'h0000);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_held", idle_c(), 16'h0000);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_release_no_done", idle_c(), 16'h0000);
    end

    // Illegal instruction held valid with a second instruction queued behind it
    instr = 16'hE000;
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("q_decode_busy", zero_c(), 16'h0000);
    instr = 16'hD27F;
    @(negedge clk);
    c = zero_c(); c.done = 1; c.err = 1;
    checkOutput("q_err", c, 16'h0000);
    @(negedge clk);
    checkOutput("q_idle_gap", idle_c(), 16'h0000);
    @(negedge clk);
    checkOutput("q_second_decode", zero_c(), 16'h007F);
    instr_valid = 1'b0;
    @(negedge clk);
    c = zero_c(); c.write = 1; c.writenum = 3'd2; c.vsel = 1; c.done = 1;
    checkOutput("q_second_write", c, 16'h007F);
    @(negedge clk);
    checkOutput("q_final_idle", idle_c(), 16'h007F);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
